// File: rtl/rv32_hazard_sequencer_pkg.sv
// Shared encodings for the hazard sequencer: FSM state codes and the
// per-stage stall/flush bundle.
package rv32_hazard_sequencer_pkg;

  localparam logic [1:0] STATE_RUN     = 2'd0;
  localparam logic [1:0] STATE_DRAIN   = 2'd1;
  localparam logic [1:0] STATE_RELEASE = 2'd2;

  typedef struct packed {
    logic fetch_stall;
    logic fetch_flush;
    logic decode_stall;
    logic decode_flush;
    logic ex_stall;
    logic ex_flush;
    logic mem_stall;
    logic mem_flush;
  } pipe_ctrl_t;

endpackage

// File: rtl/rv32_hazard_sequencer_watchdog.sv
// Data-bus wait watchdog: counts consecutive wait cycles (saturating) and
// raises a sticky timeout flag once the count reaches DMEM_TIMEOUT.
module rv32_hazard_sequencer_watchdog #(
  parameter int unsigned DMEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_,
  input  logic mem_wait,
  output logic bus_timeout
);

  localparam int unsigned WAIT_W = $clog2(DMEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(DMEM_TIMEOUT);

  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_next;

  // Next wait count: clear when the bus is not stalling, saturate at the limit
  always_comb begin
    wait_cnt_next = '0;
    if (mem_wait) begin
      if (wait_cnt == WAIT_MAX) wait_cnt_next = wait_cnt;
      else                      wait_cnt_next = wait_cnt + WAIT_W'(1);
    end
  end

  // Counter and sticky flag; flag sets on the edge the count reaches the limit
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wait_cnt    <= '0;
      bus_timeout <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_next;
      if (wait_cnt_next == WAIT_MAX) bus_timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/rv32_hazard_sequencer.sv
// Central stall/flush sequencer for the 5-stage pipeline. Resolves load-use
// hazards, branch mispredicts, data-bus waits and FENCE draining.
module rv32_hazard_sequencer
  import rv32_hazard_sequencer_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned DMEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic [4:0] decode_rs1_in,
  input  logic       decode_rs1_read_in,
  input  logic [4:0] decode_rs2_in,
  input  logic       decode_rs2_read_in,
  input  logic       decode_mem_fence_in,
  input  logic [4:0] ex_rd_in,
  input  logic       ex_rd_write_in,
  input  logic       ex_mem_read_in,
  input  logic       ex_branch_mispredict_in,
  input  logic       dmem_req_in,
  input  logic       dmem_ready_in,
  output logic       fetch_stall_out,
  output logic       fetch_flush_out,
  output logic       decode_stall_out,
  output logic       decode_flush_out,
  output logic       ex_stall_out,
  output logic       ex_flush_out,
  output logic       mem_stall_out,
  output logic       mem_flush_out,
  output logic       bus_timeout_out,
  output logic [1:0] state_out
);

  localparam int unsigned CNT_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DRAIN_CYCLES - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] drain_cnt;
  logic             mem_wait;
  logic             load_use;
  logic             fence_entry;
  pipe_ctrl_t       ctrl;

  // Hazard conditions derived from decode/execute/memory inputs
  always_comb begin
    mem_wait = dmem_req_in & ~dmem_ready_in;
    load_use = ex_mem_read_in & ex_rd_write_in & (ex_rd_in != 5'd0) &
               ((decode_rs1_read_in & (decode_rs1_in == ex_rd_in)) |
                (decode_rs2_read_in & (decode_rs2_in == ex_rd_in)));
    fence_entry = (state == STATE_RUN) & decode_mem_fence_in;
  end

  // Prioritised per-stage stall/flush; reset forces bubbles everywhere
  always_comb begin
    ctrl = '0;
    if (!reset_) begin
      ctrl.fetch_flush  = 1'b1;
      ctrl.decode_flush = 1'b1;
      ctrl.ex_flush     = 1'b1;
      ctrl.mem_flush    = 1'b1;
    end else if (mem_wait) begin
      ctrl.fetch_stall  = 1'b1;
      ctrl.decode_stall = 1'b1;
      ctrl.ex_stall     = 1'b1;
      ctrl.mem_stall    = 1'b1;
      ctrl.mem_flush    = 1'b1;
    end else if (ex_branch_mispredict_in) begin
      ctrl.fetch_flush  = 1'b1;
      ctrl.decode_flush = 1'b1;
    end else if ((state == STATE_DRAIN) || fence_entry || load_use) begin
      ctrl.fetch_stall  = 1'b1;
      ctrl.decode_flush = 1'b1;
    end
  end

  // FENCE drain FSM. The entry cycle already holds the fence, so DRAIN is
  // left when the decremented count would reach zero, giving DRAIN_CYCLES
  // held cycles in total.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state     <= STATE_RUN;
      drain_cnt <= '0;
    end else if (!mem_wait) begin
      if (ex_branch_mispredict_in) begin
        state     <= STATE_RUN;
        drain_cnt <= '0;
      end else begin
        case (state)
          STATE_RUN: begin
            if (decode_mem_fence_in) begin
              state     <= STATE_DRAIN;
              drain_cnt <= DRAIN_INIT;
            end
          end
          STATE_DRAIN: begin
            if (drain_cnt <= CNT_W'(1)) begin
              state     <= STATE_RELEASE;
              drain_cnt <= '0;
            end else begin
              drain_cnt <= drain_cnt - CNT_W'(1);
            end
          end
          default: state <= STATE_RUN;
        endcase
      end
    end
  end

  rv32_hazard_sequencer_watchdog #(
    .DMEM_TIMEOUT (DMEM_TIMEOUT)
  ) u_watchdog (
    .clk         (clk),
    .reset_      (reset_),
    .mem_wait    (mem_wait),
    .bus_timeout (bus_timeout_out)
  );

  // Drive the individual control ports from the bundle
  always_comb begin
    fetch_stall_out  = ctrl.fetch_stall;
    fetch_flush_out  = ctrl.fetch_flush;
    decode_stall_out = ctrl.decode_stall;
    decode_flush_out = ctrl.decode_flush;
    ex_stall_out     = ctrl.ex_stall;
    ex_flush_out     = ctrl.ex_flush;
    mem_stall_out    = ctrl.mem_stall;
    mem_flush_out    = ctrl.mem_flush;
    state_out        = state;
  end

endmodule
